// File: rtl/tx_credit_counter_p_if.sv
// Flow-control interface between the TX scheduler and the credit counter.
// The master drives the FCT/char events; the slave (counter) reports credit and error status.
interface tx_credit_counter_p_if #(
  parameter int CNT_WIDTH = 6
);
  logic                 gotfct_tx;
  logic                 char_sent;
  logic [CNT_WIDTH-1:0] credit_count;
  logic                 credit_avail;
  logic                 fct_accepted;
  logic                 credit_error;
  logic                 underflow_error;

  modport master (
    output gotfct_tx, char_sent,
    input  credit_count, credit_avail, fct_accepted, credit_error, underflow_error
  );

  modport slave (
    input  gotfct_tx, char_sent,
    output credit_count, credit_avail, fct_accepted, credit_error, underflow_error
  );
endinterface

// File: rtl/tx_credit_counter_p.sv
// SpaceWire TX flow-control credit counter: FCT edges add credit, N-Char edges consume it,
// with sticky overflow (credit error) and underflow detection.
//
// state  | meaning
// S_IDLE | no credit outstanding, no error
// S_RUN  | credit > 0, TX may send
// S_ERR  | credit error latched, counter frozen until reset
module tx_credit_counter_p #(
  parameter int CNT_WIDTH      = 6,
  parameter int CREDIT_PER_FCT = 8,
  parameter int MAX_CREDIT     = 56
) (
  input logic                pclk_tx,
  input logic                enable_tx,
  tx_credit_counter_p_if.slave cc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

  localparam int AW = CNT_WIDTH + 1;
  localparam logic [AW-1:0] INC_C = AW'(CREDIT_PER_FCT);
  localparam logic [AW-1:0] MAX_C = AW'(MAX_CREDIT);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 avail_q, avail_d;
  logic                 acc_q, acc_d;
  logic                 cerr_q, cerr_d;
  logic                 uerr_q, uerr_d;
  logic                 fct_d, sent_d;

  logic                 fct_edge, sent_edge;
  logic [AW-1:0]        inc, dec, net;
  logic                 ovf;

  assign fct_edge  = cc.gotfct_tx & ~fct_d;
  assign sent_edge = cc.char_sent & ~sent_d;

  // Extra bit lets the overflow compare see net values past the counter range.
  assign inc = fct_edge ? INC_C : '0;
  assign dec = (sent_edge && (cnt_q != '0)) ? AW'(1) : '0;
  assign net = {1'b0, cnt_q} + inc - dec;
  assign ovf = (net > MAX_C);

  always_ff @(posedge pclk_tx or negedge enable_tx) begin
    if (!enable_tx) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      avail_q <= 1'b0;
      acc_q   <= 1'b0;
      cerr_q  <= 1'b0;
      uerr_q  <= 1'b0;
      fct_d   <= 1'b0;
      sent_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
      acc_q   <= acc_d;
      cerr_q  <= cerr_d;
      uerr_q  <= uerr_d;
      fct_d   <= cc.gotfct_tx;
      sent_d  <= cc.char_sent;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = 1'b0;
    cerr_d  = cerr_q;
    uerr_d  = uerr_q;
    case (state_q)
      S_IDLE: begin
        if (sent_edge) uerr_d = 1'b1;
        if (fct_edge) begin
          if (ovf) begin
            cerr_d  = 1'b1;
            state_d = S_ERR;
          end else begin
            cnt_d   = net[CNT_WIDTH-1:0];
            acc_d   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // On overflow neither increment nor decrement lands; the count holds.
        if (ovf) begin
          cerr_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = net[CNT_WIDTH-1:0];
          acc_d = fct_edge;
          if (net == '0) state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    avail_d = (state_d == S_RUN);
  end

  assign cc.credit_count    = cnt_q;
  assign cc.credit_avail    = avail_q;
  assign cc.fct_accepted    = acc_q;
  assign cc.credit_error    = cerr_q;
  assign cc.underflow_error = uerr_q;

endmodule

// File: tb/tb_tx_credit_counter_p.sv
// Scoreboard bench for tx_credit_counter_p: default (6/8/56) and wide (8/16/200) instances.
module tb_tx_credit_counter_p;

  logic pclk_tx;
  logic enable_tx;

  tx_credit_counter_p_if #(.CNT_WIDTH(6)) ifa ();
  tx_credit_counter_p_if #(.CNT_WIDTH(8)) ifb ();

  tx_credit_counter_p #(.CNT_WIDTH(6), .CREDIT_PER_FCT(8), .MAX_CREDIT(56)) dut_a (
    .pclk_tx  (pclk_tx),
    .enable_tx(enable_tx),
    .cc       (ifa)
  );

  tx_credit_counter_p #(.CNT_WIDTH(8), .CREDIT_PER_FCT(16), .MAX_CREDIT(200)) dut_b (
    .pclk_tx  (pclk_tx),
    .enable_tx(enable_tx),
    .cc       (ifb)
  );

  typedef struct {
    int cnt;
    bit avail;
    bit acc;
    bit cerr;
    bit uerr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;

  initial pclk_tx = 1'b0;
  always #5 pclk_tx = ~pclk_tx;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: each queued entry describes the outputs after the next rising edge.
  always @(posedge pclk_tx) begin
    #1;
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      check("A_count", int'(ifa.credit_count), ea.cnt);
      check("A_avail", int'(ifa.credit_avail), int'(ea.avail));
      check("A_fct_accepted", int'(ifa.fct_accepted), int'(ea.acc));
      check("A_credit_error", int'(ifa.credit_error), int'(ea.cerr));
      check("A_underflow", int'(ifa.underflow_error), int'(ea.uerr));
    end
  end

  always @(posedge pclk_tx) begin
    #1;
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      check("B_count", int'(ifb.credit_count), eb.cnt);
      check("B_avail", int'(ifb.credit_avail), int'(eb.avail));
      check("B_fct_accepted", int'(ifb.fct_accepted), int'(eb.acc));
      check("B_credit_error", int'(ifb.credit_error), int'(eb.cerr));
      check("B_underflow", int'(ifb.underflow_error), int'(eb.uerr));
    end
  end

  task automatic push(input bit sel, input int cnt, input bit acc, input bit cerr, input bit uerr);
    exp_t e;
    e.cnt   = cnt;
    e.avail = (cnt != 0) && !cerr;
    e.acc   = acc;
    e.cerr  = cerr;
    e.uerr  = uerr;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic drive(input bit sel, input bit g, input bit c, input int cnt,
                       input bit acc, input bit cerr, input bit uerr);
    @(negedge pclk_tx);
    if (sel) begin
      ifb.gotfct_tx = g;
      ifb.char_sent = c;
    end else begin
      ifa.gotfct_tx = g;
      ifa.char_sent = c;
    end
    push(sel, cnt, acc, cerr, uerr);
  endtask

  // hi cycles of the given level, then one idle cycle; acc is expected on the first cycle only.
  task automatic pulse(input bit sel, input bit g, input bit c, input int hi, input int cnt,
                       input bit acc, input bit cerr, input bit uerr);
    for (int i = 0; i < hi; i++) drive(sel, g, c, cnt, (i == 0) ? acc : 1'b0, cerr, uerr);
    drive(sel, 1'b0, 1'b0, cnt, 1'b0, cerr, uerr);
  endtask

  task automatic chk_zero(input bit sel, input string tag);
    if (sel) begin
      check({tag, "_B_count"}, int'(ifb.credit_count), 0);
      check({tag, "_B_flags"}, int'({ifb.credit_avail, ifb.fct_accepted,
                                     ifb.credit_error, ifb.underflow_error}), 0);
    end else begin
      check({tag, "_A_count"}, int'(ifa.credit_count), 0);
      check({tag, "_A_flags"}, int'({ifa.credit_avail, ifa.fct_accepted,
                                     ifa.credit_error, ifa.underflow_error}), 0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge pclk_tx);
    enable_tx     = 1'b0;
    ifa.gotfct_tx = 1'b0;
    ifa.char_sent = 1'b0;
    ifb.gotfct_tx = 1'b0;
    ifb.char_sent = 1'b0;
    #1;
    chk_zero(1'b0, tag);
    chk_zero(1'b1, tag);
    @(negedge pclk_tx);
    enable_tx = 1'b1;
  endtask

  initial begin
    enable_tx     = 1'b0;
    ifa.gotfct_tx = 1'b0;
    ifa.char_sent = 1'b0;
    ifb.gotfct_tx = 1'b0;
    ifb.char_sent = 1'b0;
    repeat (2) @(negedge pclk_tx);
    chk_zero(1'b0, "por");
    chk_zero(1'b1, "por");
    enable_tx = 1'b1;

    // Long FCT pulses count once each
    for (int k = 1; k <= 3; k++) pulse(1'b0, 1'b1, 1'b0, 3, 8 * k, 1'b1, 1'b0, 1'b0);
    // Drain 24 credits back to zero
    for (int k = 23; k >= 0; k--) pulse(1'b0, 1'b0, 1'b1, 1, k, 1'b0, 1'b0, 1'b0);

    // Fill to 56, then overflow; error state ignores further edges
    for (int k = 1; k <= 7; k++) pulse(1'b0, 1'b1, 1'b0, 1, 8 * k, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1, 56, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1, 56, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1, 56, 1'b0, 1'b1, 1'b0);
    do_reset("err_rst");

    // Coincident FCT and char: 48+8-1 legal, 56+8-1 overflows
    for (int k = 1; k <= 6; k++) pulse(1'b0, 1'b1, 1'b0, 1, 8 * k, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1, 55, 1'b1, 1'b0, 1'b0);
    do_reset("coin1_rst");
    for (int k = 1; k <= 7; k++) pulse(1'b0, 1'b1, 1'b0, 1, 8 * k, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b1, 1, 56, 1'b0, 1'b1, 1'b0);
    do_reset("coin2_rst");

    // Underflow is sticky and does not block later credit
    pulse(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1, 8, 1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1, 1, 7, 1'b0, 1'b0, 1'b1);
    do_reset("uf_rst");

    // FCT already high when reset releases counts on the first clock
    @(negedge pclk_tx);
    enable_tx     = 1'b0;
    ifa.gotfct_tx = 1'b1;
    #2;
    chk_zero(1'b0, "hold_in_rst");
    @(negedge pclk_tx);
    enable_tx = 1'b1;
    push(1'b0, 8, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) pulse(1'b0, 1'b1, 1'b0, 1, 8 * k, 1'b1, 1'b0, 1'b0);
    // Asynchronous reset mid-cycle at credit 40
    @(posedge pclk_tx);
    #3;
    enable_tx = 1'b0;
    #1;
    chk_zero(1'b0, "async_rst");
    @(negedge pclk_tx);
    enable_tx = 1'b1;

    // Wide instance: 12 FCTs of 16 reach 192, the 13th overflows 200
    do_reset("b_rst");
    for (int k = 1; k <= 12; k++) pulse(1'b1, 1'b1, 1'b0, 2, 16 * k, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 1, 192, 1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, 1, 192, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge pclk_tx);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain pending_a=%0d pending_b=%0d expected=0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
